// File: rtl/sha256_digest_reader.sv
// sha256_digest_reader
// Captures the 256-bit SHA-256 digest from the hash core into a shadow
// register and hands it to the host one byte per rising edge of rd_req,
// most significant byte (H0[31:24]) first. All outputs are registered.

module sha256_digest_reader (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         clr,
    input  logic         digest_valid,
    input  logic [255:0] digest_in,
    input  logic         rd_req,
    output logic [7:0]   data_out,
    output logic         data_valid,
    output logic         last,
    output logic [4:0]   byte_idx,
    output logic         busy,
    output logic         overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [255:0]   shadow_q, shadow_d;
    logic           overrun_q, overrun_d;
    logic [7:0]     data_out_q, data_out_d;
    logic           last_q, last_d;
    logic           rd_req_q;
    logic           rd_edge;
    logic [7:0]     bit_base;

    // A host read is the rising edge of the strobe, so a held strobe consumes one byte.
    assign rd_edge = rd_req & ~rd_req_q;

    // Next-state logic: clr beats the enable gate, which beats normal operation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;
        if (clr) begin
            state_d   = IDLE;
            idx_d     = 5'd0;
            overrun_d = 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (digest_valid) begin
                        shadow_d = digest_in;
                        idx_d    = 5'd0;
                        state_d  = SHOW;
                    end
                end
                SHOW: begin
                    if (digest_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (rd_edge) begin
                        if (idx_q == 5'd31) begin
                            idx_d   = 5'd0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 5'd0;
                end
            endcase
        end
    end

    // Output byte is selected from the next-cycle shadow/index so it can be registered;
    // ~idx equals 31-idx, giving big-endian byte order.
    always_comb begin
        bit_base   = {~idx_d, 3'b000};
        data_out_d = 8'h00;
        last_d     = 1'b0;
        if (state_d == SHOW) begin
            data_out_d = shadow_d[bit_base +: 8];
            last_d     = (idx_d == 5'd31);
        end
    end

    // State, shadow and registered outputs; rd_req_q samples every cycle regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 5'd0;
            shadow_q   <= '0;
            overrun_q  <= 1'b0;
            data_out_q <= 8'h00;
            last_q     <= 1'b0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
            last_q     <= last_d;
            rd_req_q   <= rd_req;
        end
    end

    assign data_out   = data_out_q;
    assign last       = last_q;
    assign byte_idx   = idx_q;
    assign data_valid = (state_q == SHOW);
    assign busy       = (state_q == SHOW);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Testbench for sha256_digest_reader: a queue of expected bytes is filled
// whenever a digest is accepted and drained as each byte is read back.

module tb_sha256_digest_reader;

    localparam logic [255:0] ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ONES = {256{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         clr = 1'b0;
    logic         digest_valid = 1'b0;
    logic [255:0] digest_in = '0;
    logic         rd_req = 1'b0;
    logic [7:0]   data_out;
    logic         data_valid;
    logic         last;
    logic [4:0]   byte_idx;
    logic         busy;
    logic         overrun;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] idx;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [15:0] obs;
    assign obs = {data_valid, busy, last, byte_idx, data_out};

    sha256_digest_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .clr          (clr),
        .digest_valid (digest_valid),
        .digest_in    (digest_in),
        .rd_req       (rd_req),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .last         (last),
        .byte_idx     (byte_idx),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Observed-output pattern expected while a given byte is on the bus.
    function automatic logic [15:0] showing(input exp_t x);
        return {1'b1, 1'b1, x.last, x.idx, x.data};
    endfunction

    task automatic push_digest(input logic [255:0] d);
        exp_t x;
        for (int k = 0; k < 32; k++) begin
            x.data = d[255 - 8*k -: 8];
            x.idx  = k[4:0];
            x.last = (k == 31);
            sb.push_back(x);
        end
    endtask

    // All stimulus tasks start and end just after a falling clock edge.
    task automatic load(input logic [255:0] d);
        digest_in    = d;
        digest_valid = 1'b1;
        push_digest(d);
        @(negedge clk);
        digest_valid = 1'b0;
    endtask

    task automatic strobe();
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic abort();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reset();
        ena = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({overrun, obs} !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %h expected %h", {overrun, obs}, 17'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        strobe();
        n_checks++;
        if ({overrun, obs} !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL idle_ignores_read: got %h expected %h", {overrun, obs}, 17'd0);
        end
    endtask

    task automatic test_full_readout();
        load(ABC);
        n_checks++;
        if (data_out !== 8'hba) begin
            n_fail++;
            $display("[TB] FAIL first_byte: got %h expected %h", data_out, 8'hba);
        end
        for (int k = 0; k < 32; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs !== showing(e)) begin
                n_fail++;
                $display("[TB] FAIL readout_byte%0d: got %h expected %h", k, obs, showing(e));
            end
            strobe();
        end
        n_checks++;
        if ({overrun, obs} !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL post_readout_idle: got %h expected %h", {overrun, obs}, 17'd0);
        end
    endtask

    task automatic test_hold();
        load(ABC);
        e = sb.pop_front();
        n_checks++;
        if (obs !== showing(e)) begin
            n_fail++;
            $display("[TB] FAIL hold_byte0: got %h expected %h", obs, showing(e));
        end
        rd_req = 1'b1;
        repeat (10) @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (obs !== showing(e) || data_out !== 8'h78) begin
            n_fail++;
            $display("[TB] FAIL hold_one_advance: got %h expected %h", obs, showing(e));
        end
        abort();
    endtask

    task automatic test_overrun();
        load(ABC);
        for (int k = 0; k < 5; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs !== showing(e)) begin
                n_fail++;
                $display("[TB] FAIL ovr_byte%0d: got %h expected %h", k, obs, showing(e));
            end
            strobe();
        end
        digest_in    = ONES;
        digest_valid = 1'b1;
        @(negedge clk);
        digest_valid = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overrun_set: got %b expected %b", overrun, 1'b1);
        end
        for (int k = 5; k < 31; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs !== showing(e)) begin
                n_fail++;
                $display("[TB] FAIL ovr_byte%0d: got %h expected %h", k, obs, showing(e));
            end
            strobe();
        end
        e = sb.pop_front();
        n_checks++;
        if (obs !== showing(e) || data_out !== 8'had) begin
            n_fail++;
            $display("[TB] FAIL ovr_byte31: got %h expected %h", obs, showing(e));
        end
        // Final read edge and a new digest in the same cycle, digest held one more cycle.
        rd_req       = 1'b1;
        digest_valid = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        push_digest(ONES);
        n_checks++;
        if ({overrun, obs} !== {1'b1, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL final_edge_idle: got %h expected %h", {overrun, obs}, {1'b1, 16'd0});
        end
        @(negedge clk);
        digest_valid = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (obs !== showing(e) || data_out !== 8'hff) begin
            n_fail++;
            $display("[TB] FAIL accept_after_busy: got %h expected %h", obs, showing(e));
        end
        abort();
    endtask

    task automatic test_ena();
        exp_t e3;
        load(ABC);
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs !== showing(e)) begin
                n_fail++;
                $display("[TB] FAIL ena_byte%0d: got %h expected %h", k, obs, showing(e));
            end
            strobe();
        end
        e3 = sb.pop_front();
        ena = 1'b0;
        repeat (3) strobe();
        digest_in    = ONES;
        digest_valid = 1'b1;
        @(negedge clk);
        digest_valid = 1'b0;
        n_checks++;
        if ({overrun, obs} !== {1'b0, showing(e3)}) begin
            n_fail++;
            $display("[TB] FAIL ena_low_frozen: got %h expected %h", {overrun, obs}, {1'b0, showing(e3)});
        end
        ena = 1'b1;
        strobe();
        e = sb.pop_front();
        n_checks++;
        if (obs !== showing(e) || data_out !== 8'h8f) begin
            n_fail++;
            $display("[TB] FAIL ena_resume_byte4: got %h expected %h", obs, showing(e));
        end
        abort();
    endtask

    task automatic test_clr();
        load(ABC);
        for (int k = 0; k < 20; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs !== showing(e)) begin
                n_fail++;
                $display("[TB] FAIL clr_byte%0d: got %h expected %h", k, obs, showing(e));
            end
            strobe();
        end
        digest_in    = ONES;
        digest_valid = 1'b1;
        @(negedge clk);
        digest_valid = 1'b0;
        e = sb[0];
        n_checks++;
        if ({overrun, obs} !== {1'b1, showing(e)}) begin
            n_fail++;
            $display("[TB] FAIL clr_setup_byte20: got %h expected %h", {overrun, obs}, {1'b1, showing(e)});
        end
        clr    = 1'b1;
        rd_req = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
        rd_req = 1'b0;
        n_checks++;
        if ({overrun, obs} !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL clr_to_idle: got %h expected %h", {overrun, obs}, 17'd0);
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        load(ABC);
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (obs !== showing(e)) begin
                n_fail++;
                $display("[TB] FAIL arst_byte%0d: got %h expected %h", k, obs, showing(e));
            end
            strobe();
        end
        digest_valid = 1'b1;
        @(negedge clk);
        digest_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({overrun, obs} !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h expected %h", {overrun, obs}, 17'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        load(ABC);
        e = sb.pop_front();
        n_checks++;
        if (obs !== showing(e)) begin
            n_fail++;
            $display("[TB] FAIL after_reset_load: got %h expected %h", obs, showing(e));
        end
        abort();
    endtask

    initial begin
        test_reset();
        test_full_readout();
        test_hold();
        test_overrun();
        test_ena();
        test_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
